// File: rtl/oneshot_arb_pkg.sv
// Shared types and helpers for the one-shot pulse arbiter.
// Holds the FSM state encoding and the round-robin first-set search.
package oneshot_arb_pkg;

  localparam int unsigned StateWidth = 2;
  localparam int unsigned MaxReq     = 16;

  typedef enum logic [StateWidth-1:0] {
    StIdle,
    StPulse,
    StGap
  } state_e;

  // First set bit of req[0 +: n], searching upward from (last+1) mod n.
  function automatic logic [3:0] rr_pick(input logic [MaxReq-1:0] req,
                                         input logic [3:0]        last,
                                         input int unsigned       n);
    logic [3:0] pick;
    logic [3:0] idx;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      idx = 4'((32'(last) + k) % n);
      if (k <= n && !found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/neg_edge_latch.sv
// One requester channel: falling-edge detector, pending latch and sticky overrun flag.
// A same-cycle edge and grant keep the channel pending as a fresh request.
module neg_edge_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  input  logic grant_clr,
  output logic pending,
  output logic overrun
);

  logic prev_q;
  logic pending_q;
  logic overrun_q;
  logic fall;

  assign fall = prev_q & ~line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // prev resets high so a line held low through reset yields one request
      prev_q    <= 1'b1;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      prev_q    <= line;
      pending_q <= fall | (pending_q & ~grant_clr);
      overrun_q <= overrun_q | (fall & pending_q & ~grant_clr);
    end
  end

  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/oneshot_pulse_arbiter.sv
// Round-robin arbiter sharing one active-low one-shot strobe among NUM_REQ requesters.
// Each grant drives PULSE_LEN low cycles, then GAP_LEN holdoff cycles, then one IDLE cycle.
module oneshot_pulse_arbiter
  import oneshot_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned PULSE_LEN = 1,
  parameter int unsigned GAP_LEN   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         input_pulse,
  output logic                       one_shot,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [NUM_REQ-1:0]         pending,
  output logic [NUM_REQ-1:0]         overrun
);

  localparam int unsigned IdW    = $clog2(NUM_REQ);
  localparam int unsigned MaxLen = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [IdW-1:0]      last_q;
  logic [IdW-1:0]      grant_id_q;
  logic [IdW-1:0]      pick;
  logic [NUM_REQ-1:0]  grant_clr;
  logic [MaxReq-1:0]   req_ext;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = pending;
    pick                   = IdW'(rr_pick(req_ext, 4'(last_q), NUM_REQ));
    grant_clr              = '0;
    if (state_q == StIdle && |pending) grant_clr[pick] = 1'b1;
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_chan
    neg_edge_latch u_latch (
      .clk       (clk),
      .rst_n     (rst_n),
      .line      (input_pulse[i]),
      .grant_clr (grant_clr[i]),
      .pending   (pending[i]),
      .overrun   (overrun[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      last_q     <= IdW'(NUM_REQ - 1);
      grant_id_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|pending) begin
            grant_id_q <= pick;
            last_q     <= pick;
            cnt_q      <= CntW'(PULSE_LEN - 1);
            state_q    <= StPulse;
          end
        end
        StPulse: begin
          if (cnt_q == '0) begin
            if (GAP_LEN == 0) begin
              state_q <= StIdle;
            end else begin
              state_q <= StGap;
              cnt_q   <= CntW'(GAP_LEN - 1);
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StGap: begin
          if (cnt_q == '0) state_q <= StIdle;
          else             cnt_q   <= cnt_q - CntW'(1);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign one_shot    = (state_q != StPulse);
  assign grant_valid = (state_q == StPulse);
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_oneshot_pulse_arbiter.sv
// Scoreboard bench: dut_a (PULSE_LEN=1, GAP_LEN=2) checked through an expected-grant queue,
// dut_b (PULSE_LEN=4, GAP_LEN=0) used for back-to-back spacing and mid-pulse reset.
module tb_oneshot_pulse_arbiter;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] in_a, in_b;
  logic       os_a, gv_a, os_b, gv_b;
  logic [1:0] id_a, id_b;
  logic [3:0] pend_a, ovr_a, pend_b, ovr_b;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int id;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  oneshot_pulse_arbiter #(.NUM_REQ(4), .PULSE_LEN(1), .GAP_LEN(2)) dut_a (
    .clk (clk), .rst_n (rst_a), .input_pulse (in_a), .one_shot (os_a), .grant_valid (gv_a),
    .grant_id (id_a), .pending (pend_a), .overrun (ovr_a)
  );

  oneshot_pulse_arbiter #(.NUM_REQ(4), .PULSE_LEN(4), .GAP_LEN(0)) dut_b (
    .clk (clk), .rst_n (rst_b), .input_pulse (in_b), .one_shot (os_b), .grant_valid (gv_b),
    .grant_id (id_b), .pending (pend_b), .overrun (ovr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input int c);
    exp_t e;
    e.id  = id;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every rising grant_valid on dut_a must match the head of the queue.
  logic gv_prev = 1'b0;
  int   width   = 0;
  always @(negedge clk) begin
    if (rst_a) begin
      if (gv_a && !gv_prev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_grant: got id %0d at cycle %0d, expected none", id_a, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (id_a != 2'(e.id) || cyc != e.cyc) begin
            fails++;
            $display("FAIL grant: got id %0d at cycle %0d, expected id %0d at cycle %0d",
                     id_a, cyc, e.id, e.cyc);
          end
        end
        width = 1;
      end else if (gv_a) begin
        width++;
      end else if (gv_prev) begin
        check("pulse_width_a", width, 1);
      end
      gv_prev = gv_a;
    end
  end

  initial begin
    int c;
    logic spurious;
    rst_a = 1'b0;
    rst_b = 1'b0;
    in_a  = 4'b1111;
    in_b  = 4'b1111;
    #3;
    check("reset_oneshot", os_a, 1);
    check("reset_gvalid", gv_a, 0);
    check("reset_gid", id_a, 0);
    check("reset_pending", pend_a, 0);
    check("reset_overrun", ovr_a, 0);
    step(2);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Single request on channel 2; line stays low afterwards.
    step(3);
    c = cyc;
    push(2, c + 2);
    in_a = 4'b1011;
    step(1);
    check("t1_pending", pend_a, 4'b0100);
    step(8);
    check("t1_pending_clear", pend_a, 0);
    in_a = 4'b1111;
    step(2);

    // Fresh reset, then all four channels fall together.
    rst_a = 1'b0;
    step(2);
    rst_a = 1'b1;
    step(1);
    c = cyc;
    push(0, c + 2);
    push(1, c + 6);
    push(2, c + 10);
    push(3, c + 14);
    in_a = 4'b0000;
    step(1);
    check("t2_pending", pend_a, 4'b1111);
    step(16);
    in_a = 4'b1111;
    step(2);

    // Channel 1 falls, rises and falls again while still pending.
    c = cyc;
    push(0, c + 2);
    push(1, c + 6);
    in_a = 4'b1100;
    step(1);
    in_a = 4'b1110;
    step(1);
    in_a = 4'b1100;
    step(1);
    check("t3_overrun", ovr_a, 4'b0010);
    check("t3_pending", pend_a, 4'b0010);
    step(12);
    in_a = 4'b1111;
    step(2);

    // Channel 3 edge lands in the cycle its grant is issued.
    c = cyc;
    push(2, c + 2);
    push(3, c + 6);
    push(3, c + 10);
    in_a = 4'b0011;
    step(1);
    in_a = 4'b1011;
    step(4);
    in_a = 4'b0011;
    step(1);
    check("t4_pending", pend_a, 4'b1000);
    check("t4_overrun", ovr_a, 4'b0010);
    step(8);
    in_a = 4'b1111;
    step(2);
    check("queue_drained", exp_q.size(), 0);

    // dut_b: GAP_LEN=0, channels 0 and 1 together.
    c = cyc;
    in_b = 4'b1100;
    step(2);
    check("b_pulse0_start", {os_b, 2'b00, id_b}, {1'b0, 2'b00, 2'd0});
    step(3);
    check("b_pulse0_end", os_b, 0);
    step(1);
    check("b_idle_gap", {os_b, gv_b}, 2'b10);
    step(1);
    check("b_pulse1_start", {os_b, 2'b00, id_b}, {1'b0, 2'b00, 2'd1});
    in_b = 4'b1000;
    step(1);
    check("b_pending_pre_rst", pend_b, 4'b0100);
    in_b = 4'b1111;
    #2;
    rst_b = 1'b0;
    #1;
    check("b_rst_oneshot", os_b, 1);
    check("b_rst_gvalid", gv_b, 0);
    check("b_rst_pending", pend_b, 0);
    check("b_rst_gid", id_b, 0);
    #2;
    rst_b    = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (!os_b) spurious = 1'b1;
    end
    check("b_no_spurious", spurious, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
